// File: rtl/imem_loader.sv
// Loads a length-prefixed LE byte stream into instruction memory, one write per word; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
// Latency: write strobe the cycle after a word's 4th byte; done/error one cycle after the final byte.
// Backpressure: in_ready only in load states; a byte moves on in_valid && in_ready, one per cycle.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM = 3'd6
`endif
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CSUM;
`else
    localparam state_t S_END = S_DONE;
`endif

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           words_rem_q, words_rem_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           part_q, part_d;
    logic                  in_ready_q, in_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic        accept;
    logic        start_ok;
    logic [15:0] len_n;

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        words_rem_d  = words_rem_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        part_d       = part_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        accept   = in_valid && in_ready_q;
        start_ok = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
        len_n    = {in_data, len_lo_q};

        if (start_ok) begin
            state_d     = S_LEN_LO;
            words_rem_d = 16'd0;
            word_idx_d  = '0;
            byte_idx_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d      = 8'd0;
`endif
        end

        case (state_q)
            S_LEN_LO: if (accept) begin
                len_lo_d = in_data;
                state_d  = S_LEN_HI;
            end
            S_LEN_HI: if (accept) begin
                words_rem_d = len_n;
                if ({1'b0, len_n} > CAPACITY) state_d = S_ERR;
                else if (len_n == 16'd0)      state_d = S_END;
                else                          state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                byte_idx_d = byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0: part_d[7:0]   = in_data;
                    2'd1: part_d[15:8]  = in_data;
                    2'd2: part_d[23:16] = in_data;
                    default: begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q;
                        imem_wdata_d = {in_data, part_q};
                        words_rem_d  = words_rem_q - 16'd1;
                        // Index is left alone on the last word so it never wraps at full capacity.
                        if (words_rem_q == 16'd1) state_d = S_END;
                        else                      word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                    end
                endcase
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: if (accept) begin
                state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: ;
        endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept && state_q != S_CSUM) csum_d = csum_q ^ in_data;
`endif

        in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state_d == S_CSUM) in_ready_d = 1'b1;
`endif
        // Status follows the state by one cycle so the final write lands before the CPU is released.
        done_d     = (state_q == S_DONE) && !start_ok;
        error_d    = (state_q == S_ERR) && !start_ok;
        cpu_hold_d = start_ok || !(state_q == S_IDLE || state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_lo_q     <= 8'd0;
            words_rem_q  <= 16'd0;
            word_idx_q   <= '0;
            byte_idx_q   <= 2'd0;
            part_q       <= 24'd0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            words_rem_q  <= words_rem_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            part_q       <= part_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader at ADDR_WIDTH=2: table of load streams, write scoreboard, reset/restart sequence.
module tb_imem_loader;
    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, imem_we, cpu_hold, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          bp;
        bit          bad_csum;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    vec_t vecs[$];
    wr_t  exp_q[$];
    wr_t  mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   bp_phase    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write", {30'd0, imem_addr, imem_wdata}, {30'd0, mon_e.a, mon_e.d});
            end
        end
    end

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return v.w0 + 32'h10203040 * i;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bp, input bit poke_start, output bit acc);
        logic rdy;
        int   guard = 0;
        acc = 1'b0;
        while (!acc && guard < 20) begin
            in_data  = b;
            in_valid = bp ? bp_phase : 1'b1;
            start    = poke_start;
            rdy      = in_ready;
            @(posedge clk); #1;
            acc        = in_valid && rdy;
            start      = 1'b0;
            poke_start = 1'b0;
            bp_phase   = ~bp_phase;
            guard++;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_case(input vec_t v, input int max_bytes);
        logic [7:0] bq[$];
        logic [7:0] cs = 8'd0;
        logic [31:0] w;
        bit acc;
        bit ok = 1'b1;
        bq.push_back(v.n[7:0]);
        bq.push_back(v.n[15:8]);
        if (v.n <= CAP) begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = word_of(v, i);
                for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            foreach (bq[j]) cs ^= bq[j];
            bq.push_back(cs ^ {7'd0, v.bad_csum});
`endif
        end
        if (max_bytes < bq.size()) bq = bq[0:max_bytes-1];
        for (int i = 0; i < int'(v.n) && v.n <= CAP && 4*i+5 < bq.size() + (max_bytes < 1000 ? 0 : 0); i++)
            exp_q.push_back('{a: AW'(i), d: word_of(v, i)});
        pulse_start();
        check("after_start", {done, error, cpu_hold, in_ready}, 4'b0011);
        foreach (bq[j]) begin
            send_byte(bq[j], v.bp, v.bp && j == 4, acc);
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("FAIL byte_timeout: byte %0d never accepted, required acceptance within 20 cycles", j);
                ok = 1'b0;
                break;
            end
        end
        if (ok && max_bytes >= 1000) begin
            check("flags_at_last_byte", {done, error, cpu_hold}, 3'b001);
            @(posedge clk); #1;
            check("flags_final", {done, error, cpu_hold, in_ready}, {v.exp_done, v.exp_err, v.exp_err, 1'b0});
            check("writes_outstanding", exp_q.size(), 0);
        end
    endtask

    initial begin
        vec_t rst_v;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        vecs.push_back('{n: 16'd2, w0: 32'h00C001EF, w1: 32'h00018167, bp: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0});
        vecs.push_back('{n: 16'd2, w0: 32'h00C001EF, w1: 32'h00018167, bp: 1'b1, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0});
        vecs.push_back('{n: 16'd4, w0: 32'h11223344, w1: 32'hA5A55A5A, bp: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0});
        vecs.push_back('{n: 16'd5, w0: 32'h11223344, w1: 32'hA5A55A5A, bp: 1'b0, bad_csum: 1'b0, exp_done: 1'b0, exp_err: 1'b1});
        vecs.push_back('{n: 16'd0, w0: 32'h0,        w1: 32'h0,        bp: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0});
        vecs.push_back('{n: 16'd1, w0: 32'hDEADBEEF, w1: 32'h0,        bp: 1'b1, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0});
        vecs.push_back('{n: 16'h0100, w0: 32'h0,     w1: 32'h0,        bp: 1'b0, bad_csum: 1'b0, exp_done: 1'b0, exp_err: 1'b1});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back('{n: 16'd2, w0: 32'h00C001EF, w1: 32'h00018167, bp: 1'b0, bad_csum: 1'b1, exp_done: 1'b0, exp_err: 1'b1});
`endif

        repeat (2) @(posedge clk); #1;
        check("reset_outputs", {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {in_ready, imem_we, cpu_hold, done, error}, 0);

        foreach (vecs[i]) run_case(vecs[i], 1000);

        // Abort after six bytes: only the first word should have been written.
        rst_v = vecs[0];
        run_case(rst_v, 6);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_load", {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error}, 0);
        check("mid_load_writes", exp_q.size(), 0);
        reset = 1'b0;
        exp_q.delete();
        run_case(vecs[0], 1000);

        repeat (3) @(posedge clk); #1;
        check("extra_writes_after_end", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at 400us, required completion");
        $fatal(1);
    end
endmodule
